// File: rtl/karnaugh_pkg.sv
// rtl/karnaugh_pkg.sv - shared types and constants for the 4-input truth-table sweep checker
package karnaugh_pkg;

  localparam int NUM_VECTORS = 16;
  localparam int IDX_W       = 4;

  // Default expected table is led = a&b | c&d, bit i = vector {a,b,c,d} == i
  localparam logic [NUM_VECTORS-1:0] EXPECTED_DEFAULT = 16'hF888;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/karnaugh_first_mismatch.sv
// rtl/karnaugh_first_mismatch.sv - priority encoder returning the lowest set bit of a mismatch vector
module first_mismatch
  import karnaugh_pkg::*;
(
  input  logic [NUM_VECTORS-1:0] mismatch_vec,
  output logic [IDX_W-1:0]       first_idx,
  output logic                   any
);

  // Scan from the top down so the lowest set bit is the last one written
  always_comb begin
    first_idx = '0;
    any       = |mismatch_vec;
    for (int i = NUM_VECTORS - 1; i >= 0; i--) begin
      if (mismatch_vec[i]) begin
        first_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/karnaugh_sweep_checker.sv
// rtl/karnaugh_sweep_checker.sv - drives all 16 {a,b,c,d} vectors, captures led, reports verdict
module karnaugh_sweep_checker
  import karnaugh_pkg::*;
#(
  parameter int                     HOLD_CYCLES = 50,
  parameter logic [NUM_VECTORS-1:0] EXPECTED    = EXPECTED_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   a,
  output logic                   b,
  output logic                   c,
  output logic                   d,
  input  logic                   led_in,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [NUM_VECTORS-1:0] capture,
  output logic [IDX_W-1:0]       fail_idx
);

  localparam int                CNT_W     = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_VECTORS - 1);

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [CNT_W-1:0]         hold_q, hold_d;
  logic [NUM_VECTORS-1:0]   capture_q, capture_d;
  logic                     pass_q, pass_d;
  logic [IDX_W-1:0]         fail_idx_q, fail_idx_d;

  logic                     start_ok;
  logic [IDX_W-1:0]         mm_idx;
  logic                     mm_any;

  first_mismatch u_first_mismatch (
    .mismatch_vec (capture_q ^ EXPECTED),
    .first_idx    (mm_idx),
    .any          (mm_any)
  );

  // DONE accepts a start exactly like IDLE so back-to-back sweeps lose no cycle
  assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    hold_d     = hold_q;
    capture_d  = capture_q;
    pass_d     = pass_q;
    fail_idx_d = fail_idx_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start_ok) begin
          state_d   = ST_DRIVE;
          idx_d     = '0;
          hold_d    = '0;
          capture_d = '0;
          pass_d    = 1'b0;
        end
      end

      ST_DRIVE: begin
        if (hold_q == HOLD_LAST) begin
          capture_d[idx_q] = led_in;
          if (idx_q == IDX_LAST) begin
            state_d = ST_CHECK;
          end else begin
            idx_d  = idx_q + 1'b1;
            hold_d = '0;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end

      ST_CHECK: begin
        pass_d     = !mm_any;
        fail_idx_d = mm_any ? mm_idx : '0;
        state_d    = ST_DONE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      hold_q     <= '0;
      capture_q  <= '0;
      pass_q     <= 1'b0;
      fail_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      hold_q     <= hold_d;
      capture_q  <= capture_d;
      pass_q     <= pass_d;
      fail_idx_q <= fail_idx_d;
    end
  end

  // Stimulus is parked at 0 whenever no vector is being driven
  assign {a, b, c, d} = (state_q == ST_DRIVE) ? idx_q : '0;
  assign busy         = (state_q == ST_DRIVE) || (state_q == ST_CHECK);
  assign done         = (state_q == ST_DONE);
  assign pass         = pass_q;
  assign capture      = capture_q;
  assign fail_idx     = fail_idx_q;

endmodule

// File: tb/tb_karnaugh_sweep_checker.sv
// tb/tb_karnaugh_sweep_checker.sv - scoreboard bench for the sweep checker with a modelled lab block
module tb_karnaugh_sweep_checker;

  localparam int H = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        a, b, c, d;
  logic        led_in;
  logic        busy, done, pass;
  logic [15:0] capture;
  logic [3:0]  fail_idx;

  int mode = 0;

  typedef struct {
    logic [15:0] cap;
    logic        p;
    logic [3:0]  fi;
    int          done_cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;

  int cyc      = 0;
  int cur_e0   = -1;
  int n_checks = 0;
  int n_fail   = 0;
  int k;

  karnaugh_sweep_checker #(.HOLD_CYCLES(H), .EXPECTED(16'hF888)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .c        (c),
    .d        (d),
    .led_in   (led_in),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .capture  (capture),
    .fail_idx (fail_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Lab block model: 0 = a&b|c&d, 1 = vector 5 inverted, 2 = led stuck at 0
  always_comb begin
    led_in = (a & b) | (c & d);
    if (mode == 1 && {a, b, c, d} == 4'd5) led_in = ~led_in;
    if (mode == 2) led_in = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && cur_e0 >= 0) begin
      k = cyc - cur_e0;
      if (k >= 0 && k < 16 * H) check("vector", {28'd0, a, b, c, d}, k / H);
      if (k >= 0 && k <= 16 * H) check("busy_during_sweep", {31'd0, busy}, 1);
    end
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check("capture", {16'd0, capture}, {16'd0, e.cap});
        check("pass", {31'd0, pass}, {31'd0, e.p});
        check("fail_idx", {28'd0, fail_idx}, {28'd0, e.fi});
        check("done_cycle", cyc, e.done_cyc);
        check("busy_at_done", {31'd0, busy}, 0);
      end
    end
  end

  task automatic issue_start(input logic [15:0] cap, input logic p, input logic [3:0] fi);
    exp_t ne;
    start  = 1'b1;
    cur_e0 = cyc + 1;
    ne.cap = cap;
    ne.p   = p;
    ne.fi  = fi;
    ne.done_cyc = cur_e0 + 16 * H + 1;
    sb_q.push_back(ne);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    bit seen = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1;
        break;
      end
    end
    if (!seen) check("done_timeout", 0, 1);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_abcd", {28'd0, a, b, c, d}, 0);
    check("reset_busy", {31'd0, busy}, 0);
    check("reset_done", {31'd0, done}, 0);
    check("reset_pass", {31'd0, pass}, 0);
    check("reset_capture", {16'd0, capture}, 0);
    check("reset_fail_idx", {28'd0, fail_idx}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    mode = 0;
    issue_start(16'hF888, 1'b1, 4'd0);
    wait_done(200);

    repeat (3) @(negedge clk);
    mode = 1;
    issue_start(16'hF8A8, 1'b0, 4'd5);
    wait_done(200);

    repeat (3) @(negedge clk);
    mode = 2;
    issue_start(16'h0000, 1'b0, 4'd3);
    wait_done(200);

    repeat (3) @(negedge clk);
    mode = 0;
    issue_start(16'hF888, 1'b1, 4'd0);
    repeat (7 * H + 1) @(negedge clk);
    check("pre_reset_vector7", {28'd0, a, b, c, d}, 7);
    sb_q.delete();
    cur_e0 = -1;
    rst = 1'b1;
    #1;
    check("midreset_abcd", {28'd0, a, b, c, d}, 0);
    check("midreset_busy", {31'd0, busy}, 0);
    check("midreset_capture", {16'd0, capture}, 0);
    check("midreset_done", {31'd0, done}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (80) @(negedge clk);
    issue_start(16'hF888, 1'b1, 4'd0);
    wait_done(200);

    repeat (3) @(negedge clk);
    issue_start(16'hF888, 1'b1, 4'd0);
    repeat (9 * H) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(200);

    repeat (3) @(negedge clk);
    issue_start(16'hF888, 1'b1, 4'd0);
    wait_done(200);
    issue_start(16'hF888, 1'b1, 4'd0);
    wait_done(200);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
